// File: rtl/clk_en_gen.sv
// Lock-qualified clock-enable generator: PLL lock synchroniser/qualifier, downstream reset, and NUM_CH fractional-rate strobes.
// Optional feature: define CLKGEN_LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module clk_en_gen #(
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 16,
  parameter int LOCK_HOLD = 16
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic                      lock,
  input  logic [NUM_CH*ACC_W-1:0]   inc,
  output logic [NUM_CH-1:0]         en,
  output logic                      locked,
  output logic                      rst_out
`ifdef CLKGEN_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]                lock_loss_cnt
`endif
);

  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_HOLD);

  logic              s1;
  logic              s2;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              locked_next;
  logic              run;

  // locked rises on the edge at which the hold counter reaches LOCK_HOLD
  always_comb begin
    hold_next   = hold_cnt;
    locked_next = locked;
    if (!s2) begin
      hold_next   = '0;
      locked_next = 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) begin
        hold_next = hold_cnt + 1'b1;
      end
      if (hold_next == HOLD_MAX) begin
        locked_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      hold_cnt <= '0;
      locked   <= 1'b0;
      rst_out  <= 1'b1;
    end else begin
      s1       <= lock;
      s2       <= s1;
      hold_cnt <= hold_next;
      locked   <= locked_next;
      rst_out  <= ~locked_next;
    end
  end

  // Strobes advance only while qualified lock holds and the synchronised lock is still high
  assign run = s2 & locked;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc;
      logic [ACC_W:0]   sum;
      logic             strobe;

      assign sum = {1'b0, acc} + {1'b0, inc[gi*ACC_W +: ACC_W]};

      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          acc    <= '0;
          strobe <= 1'b0;
        end else if (!run) begin
          acc    <= '0;
          strobe <= 1'b0;
        end else begin
          acc    <= sum[ACC_W-1:0];
          strobe <= sum[ACC_W];
        end
      end

      assign en[gi] = strobe;
    end
  endgenerate

`ifdef CLKGEN_LOCK_LOSS_CNT_EN
  logic loss_event;

  assign loss_event = locked & ~s2;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_event && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule
